mem_latency_sim_responder: RTL and testbench

//  Simulation-only memory model. Accepts one request per cycle from the request-side latency

---
 rtl/mem_latency_sim_responder_pkg.sv | 40 ++++
 rtl/mem_latency_sim_responder_qptr.sv | 62 ++++++
 rtl/mem_latency_sim_responder.sv | 148 ++++++++++++++
 tb/tb_mem_latency_sim_responder.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_latency_sim_responder_pkg.sv
// Shared types and sizing for the simulation-only memory responder.
// Request/response payload structs, queue/latency constants, countdown type.
// Widths here define the responder's port and entry formats.
package mem_latency_sim_responder_pkg;

    localparam int MEM_WORDS               = 1024;
    localparam int DATA_WIDTH              = 64;
    localparam int ADDR_WIDTH              = 32;
    localparam int TAG_WIDTH               = 4;
    localparam int MEM_RESP_SIM_LATENCY    = 4;
    localparam int MEM_RESP_SIM_QUEUE_SIZE = 8;

    // Byte offset bits inside a data word, and word index width
    localparam int ADDR_LSB         = $clog2(DATA_WIDTH / 8);
    localparam int WORD_IDX_WIDTH   = $clog2(MEM_WORDS);
    localparam int RESP_COUNT_WIDTH = $clog2(MEM_RESP_SIM_LATENCY + 1);

    typedef logic [RESP_COUNT_WIDTH-1:0] RespCountPath;
    typedef logic [WORD_IDX_WIDTH-1:0]   MemWordIndexPath;

    typedef struct packed {
        logic                  is_write;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
        logic [TAG_WIDTH-1:0]  tag;
    } MemRespSimRequestPath;

    typedef struct packed {
        logic                  is_write;
        logic [TAG_WIDTH-1:0]  tag;
        logic [DATA_WIDTH-1:0] data;
    } MemRespSimResponsePath;

    // Countdown loaded into a freshly enqueued entry; the entry is due
    // once it reaches zero.
    function automatic RespCountPath resp_count_init();
        return RespCountPath'(MEM_RESP_SIM_LATENCY - 1);
    endfunction

endpackage

// File: rtl/mem_latency_sim_responder_qptr.sv
// Head/tail pointer and occupancy tracker for a circular queue.
// Pointers and flags are registered; they update on the edge of push/pop.
// Caller must not push when full or pop when empty; pointers wrap modulo SIZE.
module QueuePointer #(
    parameter int SIZE             = 8,
    parameter int INITIAL_HEAD_PTR = 0,
    parameter int INITIAL_TAIL_PTR = 0,
    parameter int INITIAL_COUNT    = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push_i,
    input  logic                    pop_i,
    output logic                    full_o,
    output logic                    empty_o,
    output logic [$clog2(SIZE)-1:0] head_o,
    output logic [$clog2(SIZE)-1:0] tail_o
);
    localparam int PTR_WIDTH = $clog2(SIZE);
    localparam int CNT_WIDTH = PTR_WIDTH + 1;

    logic [PTR_WIDTH-1:0] head_q, head_d;
    logic [PTR_WIDTH-1:0] tail_q, tail_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;

    // Next pointers and occupancy; simultaneous push and pop leave count unchanged
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push_i) begin
            tail_d = tail_q + 1'b1;
        end
        if (pop_i) begin
            head_d = head_q + 1'b1;
        end
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer/occupancy registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= PTR_WIDTH'(INITIAL_HEAD_PTR);
            tail_q  <= PTR_WIDTH'(INITIAL_TAIL_PTR);
            count_q <= CNT_WIDTH'(INITIAL_COUNT);
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign full_o  = (count_q == CNT_WIDTH'(SIZE));
    assign empty_o = (count_q == '0);
    assign head_o  = head_q;
    assign tail_o  = tail_q;

endmodule

// File: rtl/mem_latency_sim_responder.sv
// Simulation-only memory model: serves requests from a word array, answers in order.
// Latency: response due MEM_RESP_SIM_LATENCY cycles after acceptance (countdown per entry).
// Backpressure: head holds while resp_ready=0; req_ready drops when queue full. Macro: MEM_RESP_SIM_WRITE_ACK_EN.
module mem_latency_sim_responder
    import mem_latency_sim_responder_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_is_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [TAG_WIDTH-1:0]  req_tag,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic                  resp_is_write,
    output logic [TAG_WIDTH-1:0]  resp_tag,
    output logic [DATA_WIDTH-1:0] resp_data
);
    localparam int QS        = MEM_RESP_SIM_QUEUE_SIZE;
    localparam int PTR_WIDTH = $clog2(QS);

    MemRespSimRequestPath  req;
    MemRespSimResponsePath new_entry;
    MemRespSimResponsePath head_entry;
    MemWordIndexPath       word_idx;

    logic [PTR_WIDTH-1:0] head_ptr;
    logic [PTR_WIDTH-1:0] tail_ptr;
    logic                 q_full;
    logic                 q_empty;
    logic                 req_accept;
    logic                 push;
    logic                 pop;
    logic                 head_due;
    logic                 unused_addr_bits;

    MemRespSimResponsePath entry_q [QS];
    RespCountPath          count_q [QS];
    RespCountPath          count_d [QS];

    // Backing store is a simulation model: it starts at zero and is never
    // touched by rst, so it carries a declaration initialiser rather than a reset.
    logic [DATA_WIDTH-1:0] mem_q [MEM_WORDS] = '{default: '0};

    QueuePointer #(
        .SIZE             (QS),
        .INITIAL_HEAD_PTR (0),
        .INITIAL_TAIL_PTR (0),
        .INITIAL_COUNT    (0)
    ) u_qptr (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .full_o  (q_full),
        .empty_o (q_empty),
        .head_o  (head_ptr),
        .tail_o  (tail_ptr)
    );

    // Upper address bits alias onto the array; byte offset bits are ignored
    assign unused_addr_bits = ^{req_addr[ADDR_WIDTH-1:ADDR_LSB+WORD_IDX_WIDTH],
                                req_addr[ADDR_LSB-1:0]};

    // Decode request, decide acceptance/enqueue and build the entry (read snapshot)
    always_comb begin
        req        = '{is_write: req_is_write, addr: req_addr, wdata: req_wdata, tag: req_tag};
        word_idx   = req.addr[ADDR_LSB +: WORD_IDX_WIDTH];
        req_accept = req_valid && !q_full;
        new_entry  = '0;
`ifdef MEM_RESP_SIM_WRITE_ACK_EN
        push               = req_accept;
        new_entry.is_write = req.is_write;
`else
        push               = req_accept && !req.is_write;
        new_entry.is_write = 1'b0;
`endif
        new_entry.tag  = req.tag;
        new_entry.data = req.is_write ? '0 : mem_q[word_idx];
    end

    // Head is due when its countdown expired; outputs are zero unless due
    always_comb begin
        head_entry    = entry_q[head_ptr];
        head_due      = !q_empty && (count_q[head_ptr] == '0);
        pop           = head_due && resp_ready;
        req_ready     = !q_full;
        resp_valid    = head_due;
        resp_is_write = head_due ? head_entry.is_write : 1'b0;
        resp_tag      = head_due ? head_entry.tag : '0;
        resp_data     = head_due ? head_entry.data : '0;
    end

    // Every countdown saturates toward zero; the slot being filled reloads
    always_comb begin
        for (int i = 0; i < QS; i++) begin
            count_d[i] = (count_q[i] == '0) ? '0 : count_q[i] - 1'b1;
            if (push && (tail_ptr == PTR_WIDTH'(i))) begin
                count_d[i] = resp_count_init();
            end
        end
    end

    // Countdown registers
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < QS; i++) begin
                count_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < QS; i++) begin
                count_q[i] <= count_d[i];
            end
        end
    end

    // Entry payload capture; validity is tracked by the queue pointers
    always_ff @(posedge clk) begin
        if (push) begin
            entry_q[tail_ptr] <= new_entry;
        end
    end

    // Array write on acceptance; unaffected by rst
    always_ff @(posedge clk) begin
        if (req_accept && req.is_write) begin
            mem_q[word_idx] <= req.wdata;
        end
    end

`ifndef RSD_SYNTHESIS
    // Requesters must honour req_ready; an offered request while full is lost
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(req_valid && !req_ready))
                else $error("response queue overflow");
        end
    end
`else
    // This model must never reach a synthesis build
    if (1) begin : g_sim_only_guard
        $error("mem_latency_sim_responder is a simulation-only model");
    end
`endif

endmodule

// File: tb/tb_mem_latency_sim_responder.sv
// Self-checking bench for mem_latency_sim_responder.
// Scoreboard of expected responses fed on request acceptance, checked on handshake.
// Directed checks for reset, latency, stall hold, full, and reset flush.
module tb_mem_latency_sim_responder;
    import mem_latency_sim_responder_pkg::*;

`ifdef MEM_RESP_SIM_WRITE_ACK_EN
    localparam bit ACK_EN = 1'b1;
`else
    localparam bit ACK_EN = 1'b0;
`endif

    logic                  clk;
    logic                  rst;
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_is_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [TAG_WIDTH-1:0]  req_tag;
    logic                  resp_valid;
    logic                  resp_ready;
    logic                  resp_is_write;
    logic [TAG_WIDTH-1:0]  resp_tag;
    logic [DATA_WIDTH-1:0] resp_data;

    mem_latency_sim_responder dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_is_write  (req_is_write),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .req_tag       (req_tag),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_is_write (resp_is_write),
        .resp_tag      (resp_tag),
        .resp_data     (resp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic                  w;
        logic [TAG_WIDTH-1:0]  tag;
        logic [DATA_WIDTH-1:0] data;
    } exp_t;

    exp_t                  sb [$];
    logic [DATA_WIDTH-1:0] mdl_mem [MEM_WORDS];

    bit                    stalled;
    logic                  held_w;
    logic [TAG_WIDTH-1:0]  held_tag;
    logic [DATA_WIDTH-1:0] held_data;

    initial begin
        for (int i = 0; i < MEM_WORDS; i++) mdl_mem[i] = '0;
        stalled = 1'b0;
    end

    // Mid-cycle monitor: compare handshakes against the scoreboard, check
    // hold-while-stalled, and record newly accepted requests in the model.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                check_eq("hold_valid", resp_valid, 1'b1);
                check_eq("hold_tag", resp_tag, held_tag);
                check_eq("hold_data", resp_data, held_data);
                check_eq("hold_w", resp_is_write, held_w);
            end
            if (resp_valid && resp_ready) begin
                if (sb.size() == 0) begin
                    check_eq("unexpected_resp", 1'b1, 1'b0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check_eq("sb_tag", resp_tag, e.tag);
                    check_eq("sb_data", resp_data, e.data);
                    check_eq("sb_w", resp_is_write, e.w);
                end
            end
            stalled   = resp_valid && !resp_ready;
            held_w    = resp_is_write;
            held_tag  = resp_tag;
            held_data = resp_data;
            if (req_valid && req_ready) begin
                int idx;
                idx = int'(req_addr[ADDR_LSB +: WORD_IDX_WIDTH]);
                if (req_is_write) begin
                    mdl_mem[idx] = req_wdata;
                    if (ACK_EN) sb.push_back('{w: 1'b1, tag: req_tag, data: '0});
                end else begin
                    sb.push_back('{w: 1'b0, tag: req_tag, data: mdl_mem[idx]});
                end
            end
        end
    end

    // All driving happens 1 time unit after the rising edge
    task automatic req_cycle(input logic w, input logic [31:0] a, input logic [63:0] d, input logic [3:0] t);
        req_valid    = 1'b1;
        req_is_write = w;
        req_addr     = a;
        req_wdata    = d;
        req_tag      = t;
        @(posedge clk); #1;
        req_valid    = 1'b0;
    endtask

    task automatic issue(input logic w, input logic [31:0] a, input logic [63:0] d, input logic [3:0] t);
        int n;
        n = 0;
        while (!req_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!req_ready) check_eq("ready_timeout", 1'b0, 1'b1);
        else req_cycle(w, a, d, t);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_read_resp(input string name, output logic [3:0] t, output logic [63:0] d);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(resp_valid && !resp_is_write) && n < 50);
        if (!(resp_valid && !resp_is_write)) check_eq({name, "_timeout"}, 1'b0, 1'b1);
        t = resp_tag;
        d = resp_data;
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    bit streaming;

    initial begin
        logic [3:0]  t;
        logic [63:0] d;
        int          n;
        rst          = 1'b1;
        req_valid    = 1'b0;
        req_is_write = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        req_tag      = '0;
        resp_ready   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset then idle
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_eq("idle_valid", resp_valid, 1'b0);
            check_eq("idle_ready", req_ready, 1'b1);
            if (i == 0) begin
                check_eq("idle_tag", resp_tag, '0);
                check_eq("idle_data", resp_data, '0);
                check_eq("idle_w", resp_is_write, 1'b0);
            end
        end
        @(posedge clk); #1;

        // Write then read-after-write with latency check
        req_cycle(1'b1, 32'h40, 64'hDEAD, 4'd0);
        req_cycle(1'b0, 32'h40, 64'h0, 4'd3);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq($sformatf("lat_%0d", i), resp_valid, (i == 3) || (ACK_EN && i == 2));
            if (i == 3) begin
                check_eq("raw_tag", resp_tag, 4'd3);
                check_eq("raw_data", resp_data, 64'hDEAD);
            end
        end
        @(posedge clk); #1;
        idle(4);

        // Read snapshot unaffected by a later write; subsequent read sees new data
        req_cycle(1'b0, 32'h80, 64'h0, 4'd1);
        req_cycle(1'b1, 32'h80, 64'h55, 4'd0);
        wait_read_resp("war1", t, d);
        check_eq("war_old_tag", t, 4'd1);
        check_eq("war_old_data", d, 64'h0);
        req_cycle(1'b0, 32'h80, 64'h0, 4'd2);
        wait_read_resp("war2", t, d);
        check_eq("war_new_tag", t, 4'd2);
        check_eq("war_new_data", d, 64'h55);
        idle(4);

        // Fill the queue while stalled, then drain back-to-back in order
        resp_ready = 1'b0;
        for (int i = 0; i < 8; i++) req_cycle(1'b0, 32'h1000 + 32'(8 * i), 64'h0, 4'(i));
        @(negedge clk);
        check_eq("full_ready", req_ready, 1'b0);
        @(posedge clk); #1;
        idle(5);
        @(negedge clk);
        check_eq("full_ready_hold", req_ready, 1'b0);
        check_eq("full_head_valid", resp_valid, 1'b1);
        check_eq("full_head_tag", resp_tag, 4'd0);
        @(posedge clk); #1;
        resp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check_eq($sformatf("drain_valid_%0d", i), resp_valid, 1'b1);
            check_eq($sformatf("drain_tag_%0d", i), resp_tag, 4'(i));
        end
        @(negedge clk);
        check_eq("drain_done", resp_valid, 1'b0);
        @(posedge clk); #1;

        // Streaming reads with resp_ready toggling every cycle
        for (int i = 0; i < 8; i++) issue(1'b1, 32'h2000 + 32'(8 * i), {$urandom, $urandom}, 4'(i));
        streaming = 1'b1;
        fork
            begin
                for (int i = 0; i < 24; i++) issue(1'b0, 32'h2000 + 32'(8 * $urandom_range(0, 7)), 64'h0, 4'(i));
                streaming = 1'b0;
            end
            begin
                while (streaming) begin
                    resp_ready = ~resp_ready;
                    @(posedge clk); #1;
                end
            end
        join
        resp_ready = 1'b1;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("stream_drained", sb.size(), 0);
        idle(2);

        // Reset with entries in flight; array content survives
        resp_ready = 1'b0;
        req_cycle(1'b1, 32'h3000, 64'hBEEF, 4'd0);
        req_cycle(1'b0, 32'h1000, 64'h0, 4'd1);
        req_cycle(1'b0, 32'h1008, 64'h0, 4'd2);
        req_cycle(1'b0, 32'h1010, 64'h0, 4'd3);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_valid", resp_valid, 1'b0);
        check_eq("rst_ready", req_ready, 1'b1);
        check_eq("rst_tag", resp_tag, '0);
        @(posedge clk); #1;
        resp_ready = 1'b1;
        req_cycle(1'b0, 32'h3000, 64'h0, 4'd4);
        wait_read_resp("post_rst", t, d);
        check_eq("post_rst_tag", t, 4'd4);
        check_eq("post_rst_data", d, 64'hBEEF);
        idle(2);

`ifdef MEM_RESP_SIM_WRITE_ACK_EN
        // Write acknowledge timing and content
        req_cycle(1'b1, 32'h3008, 64'h1234, 4'd7);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq($sformatf("ack_lat_%0d", i), resp_valid, i == 3);
            if (i == 3) begin
                check_eq("ack_w", resp_is_write, 1'b1);
                check_eq("ack_tag", resp_tag, 4'd7);
                check_eq("ack_data", resp_data, 64'h0);
            end
        end
        @(posedge clk); #1;
        idle(2);
`endif

        idle(3);
        check_eq("sb_empty_end", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
